// File: rtl/imem_loader.sv
// Instruction memory with a framed byte-stream program loader.
// Frame: LEN (1..255), LEN program bytes, CHK. The image is accepted when the
// 8-bit sum of the program bytes plus CHK is zero; the CPU is held in reset
// until an accepted image is present.
module imem_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_data,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_CHK,
    S_RUN,
    S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                cpu_rst_q, load_done_q, load_err_q;
  logic                mem_we;
  logic                xfer;
  logic [DATA_W-1:0]   sum_next;

  logic [DATA_W-1:0]   mem_q [2**ADDR_W];

  // Control registers: state, write pointer, byte count, running sum, status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cpu_rst_q   <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      cpu_rst_q   <= (state_d != S_RUN);
      load_done_q <= (state_d == S_RUN);
      load_err_q  <= (state_d == S_ERROR);
    end
  end

  // Program storage write; contents deliberately survive reset and aborted loads.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= ld_data;
    end
  end

  // Next-state logic; ld_start wins over a same-cycle transfer, dropping that byte.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    mem_we   = 1'b0;
    ld_ready = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_CHK);
    xfer     = ld_valid && ld_ready;
    sum_next = sum_q + ld_data;

    if (ld_start) begin
      state_d  = S_HDR;
      wr_ptr_d = '0;
      sum_d    = '0;
    end else if (xfer) begin
      case (state_q)
        S_HDR: begin
          if (ld_data == '0) begin
            state_d = S_ERROR;
          end else begin
            cnt_d   = ld_data;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          sum_d    = sum_next;
          cnt_d    = cnt_q - DATA_W'(1);
          if (cnt_q == DATA_W'(1)) begin
            state_d = S_CHK;
          end
        end
        S_CHK: begin
          state_d = (sum_next == '0) ? S_RUN : S_ERROR;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign imem_data = (state_q == S_RUN) ? mem_q[imem_addr] : '0;
  assign cpu_rst   = cpu_rst_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, good/bad loads, handshake gaps,
// zero-length frame, restart and reset in the middle of a load.
module tb_imem_loader;

  logic       clk;
  logic       rst;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       cpu_rst;
  logic       load_done;
  logic       load_err;

  int n_cmp;
  int n_fail;

  imem_loader #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .cpu_rst   (cpu_rst),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_data  = b;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst); end
    n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
    n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_load_done: got %b want 0", load_done); end
    n_cmp++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL reset_load_err: got %b want 0", load_err); end
    for (int a = 0; a < 256; a += 85) begin
      imem_addr = 8'(a);
      #1;
      n_cmp++; if (imem_data !== 8'h00) begin n_fail++; $display("FAIL reset_imem_data[%0d]: got %h want 00", a, imem_data); end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_good_load();
    logic [7:0] frame [5];
    frame = '{8'h03, 8'h10, 8'h20, 8'h30, 8'hA0};
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL good_ready_%0d: got %b want 1", i, ld_ready); end
      n_cmp++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL good_cpu_rst_hold_%0d: got %b want 1", i, cpu_rst); end
      push(frame[i]);
    end
    ld_valid = 1'b0;
    n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL good_ready_after: got %b want 0", ld_ready); end
    n_cmp++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL good_load_done: got %b want 1", load_done); end
    n_cmp++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL good_cpu_rst: got %b want 0", cpu_rst); end
    n_cmp++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL good_load_err: got %b want 0", load_err); end
    for (int a = 0; a < 3; a++) begin
      imem_addr = 8'(a);
      #1;
      n_cmp++; if (imem_data !== frame[a+1]) begin n_fail++; $display("FAIL good_fetch[%0d]: got %h want %h", a, imem_data, frame[a+1]); end
    end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] bad [5];
    logic [7:0] good [5];
    bad  = '{8'h03, 8'h10, 8'h20, 8'h30, 8'hA1};
    good = '{8'h03, 8'h10, 8'h20, 8'h30, 8'hA0};
    pulse_start();
    n_cmp++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL bad_restart_cpu_rst: got %b want 1", cpu_rst); end
    n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL bad_restart_done: got %b want 0", load_done); end
    for (int i = 0; i < 5; i++) push(bad[i]);
    ld_valid = 1'b0;
    imem_addr = 8'd1;
    #1;
    n_cmp++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL bad_load_err: got %b want 1", load_err); end
    n_cmp++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL bad_cpu_rst: got %b want 1", cpu_rst); end
    n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL bad_load_done: got %b want 0", load_done); end
    n_cmp++; if (imem_data !== 8'h00) begin n_fail++; $display("FAIL bad_imem_data: got %h want 00", imem_data); end
    // bytes offered while in ERROR must be refused
    push(8'h5A);
    ld_valid = 1'b0;
    n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL bad_err_ready: got %b want 0", ld_ready); end
    pulse_start();
    for (int i = 0; i < 5; i++) push(good[i]);
    ld_valid = 1'b0;
    n_cmp++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL bad_recover_done: got %b want 1", load_done); end
    n_cmp++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL bad_recover_err: got %b want 0", load_err); end
  endtask

  task automatic test_handshake_gaps();
    logic [7:0] frame [4];
    logic [7:0] junk  [4];
    frame = '{8'h02, 8'h55, 8'hAA, 8'h01};
    junk  = '{8'hFF, 8'h00, 8'h3C, 8'h99};
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b0;
      ld_data  = junk[i];
      tick();
      push(frame[i]);
    end
    ld_valid = 1'b0;
    n_cmp++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL gaps_load_done: got %b want 1", load_done); end
    n_cmp++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL gaps_cpu_rst: got %b want 0", cpu_rst); end
    imem_addr = 8'd0; #1;
    n_cmp++; if (imem_data !== 8'h55) begin n_fail++; $display("FAIL gaps_fetch0: got %h want 55", imem_data); end
    imem_addr = 8'd1; #1;
    n_cmp++; if (imem_data !== 8'hAA) begin n_fail++; $display("FAIL gaps_fetch1: got %h want AA", imem_data); end
    imem_addr = 8'd2; #1;
    n_cmp++; if (imem_data !== 8'h30) begin n_fail++; $display("FAIL gaps_stale2: got %h want 30", imem_data); end
  endtask

  task automatic test_len_zero();
    pulse_start();
    push(8'h00);
    ld_valid = 1'b0;
    n_cmp++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL len0_load_err: got %b want 1", load_err); end
    n_cmp++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL len0_cpu_rst: got %b want 1", cpu_rst); end
    n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL len0_ready: got %b want 0", ld_ready); end
  endtask

  task automatic test_restart_and_reset();
    pulse_start();
    push(8'h04);
    push(8'h11);
    push(8'h22);
    ld_start = 1'b1;
    push(8'h33);
    ld_start = 1'b0;
    ld_valid = 1'b0;
    n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL restart_hdr_ready: got %b want 1", ld_ready); end
    n_cmp++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL restart_hdr_err: got %b want 0", load_err); end
    push(8'h01);
    push(8'h7F);
    push(8'h81);
    ld_valid = 1'b0;
    n_cmp++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL restart_done: got %b want 1", load_done); end
    imem_addr = 8'd0; #1;
    n_cmp++; if (imem_data !== 8'h7F) begin n_fail++; $display("FAIL restart_fetch0: got %h want 7F", imem_data); end
    // byte 22 from the aborted frame stays; dropped byte 33 never lands at addr 2
    imem_addr = 8'd1; #1;
    n_cmp++; if (imem_data !== 8'h22) begin n_fail++; $display("FAIL restart_stale1: got %h want 22", imem_data); end
    imem_addr = 8'd2; #1;
    n_cmp++; if (imem_data !== 8'h30) begin n_fail++; $display("FAIL restart_drop2: got %h want 30", imem_data); end

    pulse_start();
    push(8'h03);
    push(8'h44);
    ld_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL midrst_cpu_rst: got %b want 1", cpu_rst); end
    n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b want 0", ld_ready); end
    n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", load_done); end
    push(8'h55);
    ld_valid = 1'b0;
    n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_idle_ready: got %b want 0", ld_ready); end
    n_cmp++; if (imem_data !== 8'h00) begin n_fail++; $display("FAIL midrst_imem_data: got %h want 00", imem_data); end
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    ld_start  = 1'b0;
    ld_valid  = 1'b0;
    ld_data   = 8'h00;
    imem_addr = 8'h00;
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_handshake_gaps();
    test_len_zero();
    test_restart_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction memory with a byte-stream program loader; it is the responder on the CPU instruction fetch interface.
- The pc block drives imem_addr; this block returns imem_data to regs and the mcu.
- A host pushes a framed program image over a valid/ready byte interface. The block writes the image into memory, verifies a checksum and holds the CPU in reset until a good image is present.

Parameters:
- DATA_W, 8 (`INST_WIDTH): instruction/byte width.
- ADDR_W, 8 (`INST_DEPTH): instruction address width; memory depth is 2^ADDR_W words.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active high.
- ld_start  input  1  single-cycle pulse; begins (or restarts) a load.
- ld_valid  input  1  host byte valid.
- ld_data  input  DATA_W  host byte.
- ld_ready  output  1  loader accepts a byte this cycle.
- imem_addr  input  ADDR_W  fetch address from pc.
- imem_data  output  DATA_W  fetched instruction.
- cpu_rst  output  1  reset to mcu/regs/pc; high while no valid program.
- load_done  output  1  high in RUN.
- load_err  output  1  high in ERROR.

Behaviour:
- Frame format: LEN byte (N, 1..255), then N program bytes, then CHK byte. The image is good when (sum of the N program bytes + CHK) mod 256 == 0. LEN is not included in the sum.
- A transfer occurs only on a cycle with ld_valid && ld_ready, sampled at the rising clk edge. ld_valid without ld_ready is ignored.
- FSM states: IDLE, HDR, LOAD, CHK, RUN, ERROR.
- Reset: state=IDLE, cpu_rst=1, ld_ready=0, load_done=0, load_err=0, wr_ptr=0, remaining count=0, sum=0. Memory contents are not reset.
- IDLE / RUN / ERROR:
  - ld_start goes to HDR and clears wr_ptr and sum.
  - ld_valid is ignored.
- HDR:
  - ld_ready=1.
  - On a transfer, LEN=0 goes to ERROR.
  - Otherwise count <= LEN and the state goes to LOAD.
- LOAD:
  - ld_ready=1.
  - On a transfer: mem[wr_ptr] <= ld_data, wr_ptr++, sum <= sum + ld_data (8-bit wrap), count--.
  - When the byte written is the last one (count was 1), go to CHK.
- CHK:
  - ld_ready=1.
  - On a transfer, (sum + ld_data) mod 256 == 0 goes to RUN; otherwise go to ERROR.
- ld_start while in HDR, LOAD or CHK aborts and restarts: go to HDR and clear wr_ptr and sum. ld_start takes priority over a same-cycle transfer, and that byte is dropped.
- Registered outputs, valid the cycle after the state transition:
  - cpu_rst = 1 in every state except RUN.
  - load_done = (state==RUN).
  - load_err = (state==ERROR).
  - ld_ready is decoded from the current state, so ld_ready=0 in the cycle after the final CHK transfer.
- Latency: the CHK transfer on edge k gives cpu_rst=0 and load_done=1 after edge k. The CPU leaves reset on edge k+1.
- Fetch read port:
  - Asynchronous read: imem_data = mem[imem_addr] when state==RUN, else all zeros.
  - Addresses >= N return the stale memory contents from any previous load; this is not an error.
- A new ld_start from RUN re-asserts cpu_rst on the next edge, before any byte is written, so the CPU never fetches a partially written image.
- Reset mid-load returns to IDLE with cpu_rst=1. Bytes already written remain in memory.

Test Plan:
- Reset for 2 cycles: cpu_rst=1, ld_ready=0, load_done=0, load_err=0, imem_data=0x00 for any imem_addr.
- Good load: ld_start, then bytes 03,10,20,30,A0 with ld_valid continuously high.
  - Required: ld_ready high for 5 cycles, then load_done=1 and cpu_rst=0 one cycle after the A0 transfer.
  - Fetch reads: imem_addr=0 gives 0x10, 1 gives 0x20, 2 gives 0x30.
- Bad checksum: same frame with CHK=A1.
  - Required: load_err=1, cpu_rst stays 1, imem_data=0x00 at imem_addr=1.
  - A following ld_start plus the good frame then reaches RUN.
- Handshake gaps: frame 02,55,AA,01 with ld_valid deasserted every other cycle and garbage on ld_data while low.
  - Required: only the 4 valid bytes are counted, RUN is reached, addr 0 gives 0x55 and addr 1 gives 0xAA.
- LEN=0: ld_start, byte 00 -> ERROR on the next cycle, no memory writes.
- Restart and reset mid-load:
  - ld_start, 04,11,22, then ld_start pulsed together with ld_valid on byte 33.
  - Required: 33 is dropped and the state is HDR; frame 01,7F,81 then gives RUN with addr 0 = 0x7F.
  - Separately, rst asserted during LOAD returns to IDLE with cpu_rst=1.
